keypad_matrix_responder: RTL and testbench
==========================================

Name: keypad_matrix_responder

Overview:
- Emulates the 4-row x 3-column telephone keypad that our keypad scanner drives. It is the switch-matrix end of the scan interface.
- The scanner drives one-hot column strobes C. This block returns the row lines R for a "pressed" key, requested by the test or host logic over a valid/ready handshake.
- Each press is held for a programmed number of scan passes, then a release gap follows before the next key is accepted.
- Used as a bench/board stand-in for the physical keypad.

Parameters:
- HOLD_SCANS, 4: number of scans of the key's column during which the key reads as pressed.
- GAP_SCANS, 2: number of scans of the key's column with the key released before press_done.
- TIMEOUT_CYC, 65535: ck cycles with no scan of the key's column before the press is aborted.
- CNT_W, 16: width of the timeout counter; must hold TIMEOUT_CYC.

Ports:
- ck  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- C  in  3  column strobes from the scanner, one-hot 001/010/100.
- R  out  4  row returns to the scanner, one-hot or 0.
- key_code  in  4  requested key: 0-9 are digits, 10 is '*', 11 is '#', 12-15 are invalid.
- key_valid  in  1  request strobe.
- key_ready  out  1  high in IDLE only.
- busy  out  1  high in PRESS or RELEASE.
- press_done  out  1  one-cycle pulse when a press/release sequence completes.
- err  out  1  one-cycle pulse on an invalid code or a timeout.

Behaviour:
- Clocking and reset:
  - One clock, ck. Reset is asynchronous and active-low on rst_n.
  - Reset values: state=IDLE, R=0, key_ready=1, busy=0, press_done=0, err=0, all counters=0.
- Key map as (column, row). Column 001 is row 0001 to row 1000, and so on for each column:
  - Column 001: 1, 4, 7, '*'.
  - Column 010: 2, 5, 8, 0.
  - Column 100: 3, 6, 9, '#'.
- R path:
  - R is combinational: R = key_row when (state==PRESS and C==key_col), otherwise 0.
  - C to R latency is zero ck cycles, as with a real switch.
  - R is never nonzero outside PRESS.
- Scan event:
  - C passes through a 2-flop synchronizer.
  - A scan event is a one-cycle pulse on the synchronized transition into C==key_col, i.e. previous value != key_col and current value == key_col.
  - A C held at key_col counts once.
- IDLE:
  - key_ready=1.
  - On key_valid with code 0-11: latch key_col and key_row, clear the counters, go to PRESS next cycle.
  - On key_valid with code 12-15: err pulses on the next cycle, state stays IDLE, nothing is latched.
- PRESS:
  - Each scan event increments scan_cnt and clears tmo_cnt.
  - When scan_cnt reaches HOLD_SCANS, go to RELEASE and clear scan_cnt. The transition happens at the scan edge, so the HOLD_SCANS-th scan is counted in PRESS.
- RELEASE:
  - R=0.
  - When the scan event count reaches GAP_SCANS: pulse press_done and return to IDLE.
- Timeout:
  - In PRESS or RELEASE, tmo_cnt increments every ck cycle and saturates.
  - When tmo_cnt reaches TIMEOUT_CYC: pulse err, go to IDLE, R=0 at once. press_done does not pulse.
- Handshake:
  - key_valid is ignored while key_ready=0. There is no queue; the requester holds valid until it sees ready.
  - Acceptance happens when key_valid=1 and key_ready=1 at the ck edge.
- Simultaneous events:
  - A scan event and a timeout on the same cycle: the scan wins and tmo_cnt clears.
  - press_done and err never assert together.
- Illegal C values (000, or multi-hot): these are not scan events. R stays 0 unless C exactly equals key_col.
- Reset mid-PRESS: R drops to 0 asynchronously and no press_done is issued.

Optional Feature:
- Macro: KEYPAD_BOUNCE_EN.
- When defined:
  - For the first BOUNCE_CYC ck cycles after entering PRESS, and again after entering RELEASE, the gated row output is ANDed with a bounce bit.
  - The bounce bit toggles every BOUNCE_PER ck cycles, starting at 1 on entry to PRESS and 0 on entry to RELEASE.
  - This adds localparams BOUNCE_CYC=64 and BOUNCE_PER=8.
  - Scan counting is unchanged.
- When undefined: rows are clean, with no bounce logic synthesized.

Decomposition:
- Shared package keypad_pkg:
  - Key code constants (KEY_STAR=10, KEY_HASH=11).
  - One-hot constants COL1/COL2/COL3 and ROW1..ROW4.
  - State enum {IDLE, PRESS, RELEASE}.
  - Function key_to_colrow(code) returning {valid, col, row}.
  - The scanner will share this package.
- Sub-module col_strobe_sync: 2-flop synchronizer for C plus the match-edge detector against key_col, giving a one-cycle scan_evt output.

Test Plan:
- Press 5 (HOLD=4, GAP=2), scanner model cycling C 001→010→100 every 16 ck cycles:
  - R=0010 only while C=010, for exactly 4 column-010 windows.
  - Then R=0 for 2 more windows; press_done pulses once and key_ready returns to 1.
- Press '#': R=1000 only while C=100. Press 1: R=0001 only while C=001. R=0 in all other windows.
- key_code=13 with valid: err pulses for 1 cycle, key_ready stays 1, R stays 0, busy never asserts.
- Press 2, then hold C=000 after the first scan: err pulses after TIMEOUT_CYC cycles without a scan, state returns to IDLE, and there is no press_done.
- Assert rst_n=0 during PRESS while C=key_col: R=0 in the same cycle, and all outputs return to reset values.
- key_valid held high with a new code while busy: the second key is not accepted until press_done; it is then accepted on the cycle after press_done.

Source files
------------

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module  : keypad_pkg
// Purpose : Shared definitions for the 4x3 telephone keypad scan interface.
//           Key code constants, one-hot column/row encodings, the responder
//           state type and the key code to (column, row) lookup. Shared
//           with the keypad scanner.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package keypad_pkg;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  localparam logic [2:0] COL1 = 3'b001;
  localparam logic [2:0] COL2 = 3'b010;
  localparam logic [2:0] COL3 = 3'b100;

  localparam logic [3:0] ROW1 = 4'b0001;
  localparam logic [3:0] ROW2 = 4'b0010;
  localparam logic [3:0] ROW3 = 4'b0100;
  localparam logic [3:0] ROW4 = 4'b1000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } key_state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] col;
    logic [3:0] row;
  } key_pos_t;

  // Layout: column 1 = 1,4,7,*  column 2 = 2,5,8,0  column 3 = 3,6,9,#
  function automatic key_pos_t key_to_colrow(input logic [3:0] code);
    key_pos_t pos;
    pos = '0;
    case (code)
      4'd1:     pos = '{1'b1, COL1, ROW1};
      4'd4:     pos = '{1'b1, COL1, ROW2};
      4'd7:     pos = '{1'b1, COL1, ROW3};
      KEY_STAR: pos = '{1'b1, COL1, ROW4};
      4'd2:     pos = '{1'b1, COL2, ROW1};
      4'd5:     pos = '{1'b1, COL2, ROW2};
      4'd8:     pos = '{1'b1, COL2, ROW3};
      4'd0:     pos = '{1'b1, COL2, ROW4};
      4'd3:     pos = '{1'b1, COL3, ROW1};
      4'd6:     pos = '{1'b1, COL3, ROW2};
      4'd9:     pos = '{1'b1, COL3, ROW3};
      KEY_HASH: pos = '{1'b1, COL3, ROW4};
      default:  pos = '0;
    endcase
    return pos;
  endfunction

endpackage
`default_nettype wire

// File: rtl/col_strobe_sync.sv
`default_nettype none
// ============================================================================
// Module  : col_strobe_sync
// Purpose : Two-flop synchronizer for the scanner column strobes plus an
//           edge detector that pulses scan_evt for one cycle when the
//           synchronized strobe moves onto the latched key column.
// Ports   : ck        in   clock
//           rst_n     in   asynchronous active-low reset
//           col_in    in   raw column strobes from the scanner
//           key_col   in   one-hot column of the key being pressed
//           scan_evt  out  one-cycle pulse on entry into key_col
// Rev     : 1.0  initial release
// ============================================================================
module col_strobe_sync (
  input  logic       ck,
  input  logic       rst_n,
  input  logic [2:0] col_in,
  input  logic [2:0] key_col,
  output logic       scan_evt
);

  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] prev;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= col_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // key_col is zero until a key is latched; never report an event then.
  // Illegal strobes (000, multi-hot) can never equal a one-hot key_col.
  assign scan_evt = (|key_col) && (sync2 == key_col) && (prev != key_col);

endmodule
`default_nettype wire

// File: rtl/keypad_matrix_responder.sv
`default_nettype none
// ============================================================================
// Module  : keypad_matrix_responder
// Purpose : Switch-matrix emulation of a 4x3 telephone keypad. A requested
//           key is "pressed" for HOLD_SCANS scans of its column, then
//           released for GAP_SCANS scans before press_done. Row returns are
//           a zero-latency combinational function of the column strobes.
// Ports   : ck          in   clock
//           rst_n       in   asynchronous active-low reset
//           C   [2:0]   in   one-hot column strobes from the scanner
//           R   [3:0]   out  row returns (one-hot or zero)
//           key_code    in   0-9 digits, 10 '*', 11 '#', 12-15 invalid
//           key_valid   in   request strobe
//           key_ready   out  high in IDLE
//           busy        out  high in PRESS or RELEASE
//           press_done  out  one-cycle pulse at end of release gap
//           err         out  one-cycle pulse on invalid code or timeout
// Config  : KEYPAD_BOUNCE_EN - when defined, rows chatter for the first
//           BOUNCE_CYC cycles after entering PRESS or RELEASE.
// Rev     : 1.0  initial release
// ============================================================================
module keypad_matrix_responder
  import keypad_pkg::*;
#(
  parameter int HOLD_SCANS  = 4,
  parameter int GAP_SCANS   = 2,
  parameter int TIMEOUT_CYC = 65535,
  parameter int CNT_W       = 16
) (
  input  logic       ck,
  input  logic       rst_n,
  input  logic [2:0] C,
  output logic [3:0] R,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       busy,
  output logic       press_done,
  output logic       err
);

  localparam int                SCAN_W   = 8;
  localparam logic [SCAN_W-1:0] HOLD_LIM = SCAN_W'(HOLD_SCANS);
  localparam logic [SCAN_W-1:0] GAP_LIM  = SCAN_W'(GAP_SCANS);
  localparam logic [CNT_W-1:0]  TMO_LIM  = CNT_W'(TIMEOUT_CYC);

  key_state_t        state;
  key_state_t        state_nxt;
  logic [2:0]        key_col;
  logic [3:0]        key_row;
  logic [SCAN_W-1:0] scan_cnt;
  logic [SCAN_W-1:0] scan_cnt_inc;
  logic [CNT_W-1:0]  tmo_cnt;
  logic              scan_evt;
  logic              accept;
  logic              bad_code;
  logic              gap_done;
  logic              tmo_hit;
  logic [3:0]        row_gate;
  key_pos_t          req_pos;

  assign req_pos      = key_to_colrow(key_code);
  assign scan_cnt_inc = scan_cnt + 1'b1;

  col_strobe_sync u_sync (
    .ck       (ck),
    .rst_n    (rst_n),
    .col_in   (C),
    .key_col  (key_col),
    .scan_evt (scan_evt)
  );

  // State register
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. A scan event has priority over a timeout landing on
  // the same cycle.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    bad_code  = 1'b0;
    gap_done  = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (key_valid) begin
          if (req_pos.valid) begin
            accept    = 1'b1;
            state_nxt = PRESS;
          end else begin
            bad_code  = 1'b1;
          end
        end
      end
      PRESS: begin
        if (scan_evt) begin
          if (scan_cnt_inc == HOLD_LIM) state_nxt = RELEASE;
        end else if (tmo_cnt == TMO_LIM) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      RELEASE: begin
        if (scan_evt) begin
          if (scan_cnt_inc == GAP_LIM) begin
            gap_done  = 1'b1;
            state_nxt = IDLE;
          end
        end else if (tmo_cnt == TMO_LIM) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic. R follows C with no clock in the path, like a real switch.
  always_comb begin
    key_ready = (state == IDLE);
    busy      = (state == PRESS) || (state == RELEASE);
    row_gate  = ((state == PRESS) && (C == key_col)) ? key_row : 4'b0000;
  end

  // Latched key, counters and registered status pulses
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      key_col    <= '0;
      key_row    <= '0;
      scan_cnt   <= '0;
      tmo_cnt    <= '0;
      press_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      press_done <= gap_done;
      err        <= bad_code | tmo_hit;
      if (accept) begin
        key_col  <= req_pos.col;
        key_row  <= req_pos.row;
        scan_cnt <= '0;
        tmo_cnt  <= '0;
      end else if (busy) begin
        if (scan_evt) begin
          tmo_cnt  <= '0;
          // Restart the count when the hold phase hands over to the gap
          scan_cnt <= (state_nxt != state) ? '0 : scan_cnt_inc;
        end else if (tmo_cnt != '1) begin
          tmo_cnt  <= tmo_cnt + 1'b1;
        end
      end
    end
  end

`ifdef KEYPAD_BOUNCE_EN
  localparam int       BOUNCE_CYC = 64;
  localparam int       BOUNCE_PER = 8;
  localparam logic [6:0] BNC_LIM  = 7'(BOUNCE_CYC);
  localparam logic [2:0] PER_LIM  = 3'(BOUNCE_PER - 1);

  logic [6:0] bnc_cnt;
  logic [2:0] bnc_per;
  logic       bnc_bit;
  logic       bnc_enter;
  logic [3:0] bnc_mask;

  assign bnc_enter = (state_nxt != state) &&
                     ((state_nxt == PRESS) || (state_nxt == RELEASE));

  // Chatter starts closed on a press and open on a release
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      bnc_cnt <= BNC_LIM;
      bnc_per <= '0;
      bnc_bit <= 1'b0;
    end else if (bnc_enter) begin
      bnc_cnt <= '0;
      bnc_per <= '0;
      bnc_bit <= (state_nxt == PRESS);
    end else if (bnc_cnt != BNC_LIM) begin
      bnc_cnt <= bnc_cnt + 1'b1;
      if (bnc_per == PER_LIM) begin
        bnc_per <= '0;
        bnc_bit <= ~bnc_bit;
      end else begin
        bnc_per <= bnc_per + 1'b1;
      end
    end
  end

  assign bnc_mask = (busy && (bnc_cnt != BNC_LIM)) ? {4{bnc_bit}} : 4'b1111;
  assign R        = row_gate & bnc_mask;
`else
  assign R        = row_gate;
`endif

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_keypad_matrix_responder
// Purpose : Self-checking bench. A scanner model rotates the column strobe
//           every 16 cycles; stimulus pushes the expected outcome of each
//           request into a scoreboard that a monitor pops on press_done/err.
// Rev     : 1.0  initial release
// ============================================================================
module tb_keypad_matrix_responder;

  logic       ck = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] C = 3'b001;
  logic [3:0] R;
  logic [3:0] key_code = 4'd0;
  logic       key_valid = 1'b0;
  logic       key_ready;
  logic       busy;
  logic       press_done;
  logic       err;

  keypad_matrix_responder #(
    .HOLD_SCANS  (4),
    .GAP_SCANS   (2),
    .TIMEOUT_CYC (100),
    .CNT_W       (16)
  ) dut (
    .ck         (ck),
    .rst_n      (rst_n),
    .C          (C),
    .R          (R),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .busy       (busy),
    .press_done (press_done),
    .err        (err)
  );

  always #5 ck = ~ck;

  typedef struct {
    bit         is_err;
    logic [3:0] row;
    logic [2:0] col;
    int         windows;
    int         code;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   win_cnt    = 0;
  bit   r_was_nz   = 1'b0;
  bit   mon_en     = 1'b0;
  bit   scan_en    = 1'b0;
  int   ph         = 0;

  // Hand-written keypad layout
  function automatic logic [2:0] exp_col(input int code);
    case (code)
      1, 4, 7, 10: return 3'b001;
      2, 5, 8, 0:  return 3'b010;
      3, 6, 9, 11: return 3'b100;
      default:     return 3'b000;
    endcase
  endfunction

  function automatic logic [3:0] exp_row(input int code);
    case (code)
      1, 2, 3:    return 4'b0001;
      4, 5, 6:    return 4'b0010;
      7, 8, 9:    return 4'b0100;
      10, 0, 11:  return 4'b1000;
      default:    return 4'b0000;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic bound_expired(input string nm);
    compared++;
    mismatched++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  // Scanner model
  initial begin
    forever begin
      @(posedge ck);
      #1;
      if (scan_en) begin
        ph++;
        if (ph == 16) begin
          ph = 0;
          C  = (C == 3'b100) ? 3'b001 : (C << 1);
        end
      end
    end
  end

  // Monitor: row path against scoreboard head, outcome pops on done/err
  initial begin
    exp_t e;
    forever begin
      @(negedge ck);
      if (mon_en) begin
        if (R != 4'b0000) begin
          compared++;
          if (sb.size() == 0) begin
            mismatched++;
            $display("FAIL r_unexpected: R=%b C=%b with no request pending", R, C);
          end else if (R !== sb[0].row || C !== sb[0].col) begin
            mismatched++;
            $display("FAIL r_path key %0d: R=%b C=%b required R=%b on C=%b",
                     sb[0].code, R, C, sb[0].row, sb[0].col);
          end
          if (!r_was_nz) win_cnt++;
        end
        r_was_nz = (R != 4'b0000);
        if (press_done || err) begin
          compared++;
          if (press_done && err) begin
            mismatched++;
            $display("FAIL done_err_overlap: press_done=1 err=1 required exclusive");
          end else if (sb.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_event: press_done=%b err=%b", press_done, err);
          end else begin
            e = sb.pop_front();
            if (e.is_err != err || e.windows != win_cnt) begin
              mismatched++;
              $display("FAIL outcome key %0d: err=%b windows=%0d required err=%b windows=%0d",
                       e.code, err, win_cnt, e.is_err, e.windows);
            end
          end
          win_cnt = 0;
        end
      end
    end
  end

  // Wait until the scanner has just moved onto column col
  task automatic align_to(input logic [2:0] col);
    int n;
    n = 0;
    while (C == col && n < 200) begin @(negedge ck); n++; end
    while (C != col && n < 200) begin @(negedge ck); n++; end
    if (n >= 200) bound_expired("align");
  endtask

  task automatic request(input int code, input logic [2:0] after_col,
                         input bit is_err, input int windows);
    exp_t e;
    e.is_err  = is_err;
    e.row     = exp_row(code);
    e.col     = exp_col(code);
    e.windows = windows;
    e.code    = code;
    align_to(after_col);
    sb.push_back(e);
    key_code  = code[3:0];
    key_valid = 1'b1;
    @(posedge ck);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic wait_event(input string nm, input int bound,
                            output bit got_done, output bit got_err, output int cyc);
    cyc      = 0;
    got_done = 1'b0;
    got_err  = 1'b0;
    do begin
      @(negedge ck);
      cyc++;
    end while (!(press_done || err) && cyc < bound);
    if (press_done || err) begin
      got_done = press_done;
      got_err  = err;
    end else begin
      bound_expired(nm);
    end
  endtask

  task automatic wait_r_high(input string nm);
    int n;
    n = 0;
    while (R == 4'b0000 && n < 200) begin @(negedge ck); n++; end
    if (n >= 200) bound_expired(nm);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_R"},          32'(R),          32'h0);
    check({nm, "_key_ready"},  32'(key_ready),  32'h1);
    check({nm, "_busy"},       32'(busy),       32'h0);
    check({nm, "_press_done"}, 32'(press_done), 32'h0);
    check({nm, "_err"},        32'(err),        32'h0);
  endtask

  initial begin
    bit gd;
    bit ge;
    int cyc;
    int errs;
    bit noisy;

    repeat (3) @(posedge ck);
    #1;
    check_reset_outputs("reset");
    @(negedge ck);
    rst_n   = 1'b1;
    scan_en = 1'b1;
    mon_en  = 1'b1;

    // Key 5: four column-010 windows pressed, two released
    request(5, 3'b100, 1'b0, 4);
    wait_event("key5_wait", 1500, gd, ge, cyc);
    check("key5_done",  32'(gd),        32'h1);
    check("key5_ready", 32'(key_ready), 32'h1);
    check("key5_busy",  32'(busy),      32'h0);

    // '#' and 1
    request(11, 3'b001, 1'b0, 4);
    wait_event("hash_wait", 1500, gd, ge, cyc);
    check("hash_done", 32'(gd), 32'h1);
    request(1, 3'b010, 1'b0, 4);
    wait_event("key1_wait", 1500, gd, ge, cyc);
    check("key1_done", 32'(gd), 32'h1);

    // Invalid code 13: single err pulse, never busy, rows quiet
    @(negedge ck);
    sb.push_back('{1'b1, 4'b0000, 3'b000, 0, 13});
    key_code  = 4'd13;
    key_valid = 1'b1;
    @(posedge ck);
    #1;
    key_valid = 1'b0;
    errs  = 0;
    noisy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ck);
      if (err) errs++;
      if (busy || !key_ready || R != 4'b0000) noisy = 1'b1;
    end
    check("inv_err_pulses", 32'(errs),  32'd1);
    check("inv_quiet",      32'(noisy), 32'h0);

    // Key 2, then the scanner stalls at 000 after the first scan
    request(2, 3'b100, 1'b1, 1);
    wait_r_high("tmo_r_wait");
    repeat (6) @(negedge ck);
    scan_en = 1'b0;
    C       = 3'b000;
    wait_event("tmo_wait", 400, gd, ge, cyc);
    check("tmo_err",        32'(ge),                       32'h1);
    check("tmo_no_done",    32'(gd),                       32'h0);
    check("tmo_latency_ok", 32'(cyc >= 90 && cyc <= 110),  32'h1);
    check("tmo_ready",      32'(key_ready),                32'h1);
    @(negedge ck);
    C       = 3'b001;
    ph      = 0;
    scan_en = 1'b1;

    // Key 3 then key 6 held on key_valid while busy. Key 6 enters PRESS
    // mid-way through a column-100 window that does not count as a scan,
    // so it shows one extra row window.
    request(3, 3'b001, 1'b0, 4);
    key_code  = 4'd6;
    key_valid = 1'b1;
    sb.push_back('{1'b0, exp_row(6), exp_col(6), 5, 6});
    wait_event("hold3_wait", 1500, gd, ge, cyc);
    check("hold3_done",  32'(gd),        32'h1);
    check("hold3_ready", 32'(key_ready), 32'h1);
    @(posedge ck);
    #1;
    check("hold6_accept_busy",  32'(busy),      32'h1);
    check("hold6_accept_ready", 32'(key_ready), 32'h0);
    key_valid = 1'b0;
    wait_event("hold6_wait", 1500, gd, ge, cyc);
    check("hold6_done", 32'(gd), 32'h1);

    // Reset in the middle of a press while its column is strobed
    request(1, 3'b010, 1'b0, 4);
    wait_r_high("rst_r_wait");
    @(negedge ck);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    sb.delete();
    win_cnt  = 0;
    r_was_nz = 1'b0;
    @(negedge ck);
    @(negedge ck);
    rst_n = 1'b1;

    // Recovery press after reset
    request(5, 3'b100, 1'b0, 4);
    wait_event("post_rst_wait", 1500, gd, ge, cyc);
    check("post_rst_done", 32'(gd), 32'h1);

    repeat (4) @(negedge ck);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
